// File: rtl/tick_divider_if.sv
// Control and status bundle for tick_divider.
// master: drives en/clr/load/div_in, reads tick/sq/div_q.
// slave: the divider itself.
interface tick_divider_if #(
    parameter int DIV_W = 24
);
    logic             en;
    logic             clr;
    logic             load;
    logic [DIV_W-1:0] div_in;
    logic             tick;
    logic             sq;
    logic [DIV_W-1:0] div_q;

    modport master (
        output en,
        output clr,
        output load,
        output div_in,
        input  tick,
        input  sq,
        input  div_q
    );

    modport slave (
        input  en,
        input  clr,
        input  load,
        input  div_in,
        output tick,
        output sq,
        output div_q
    );
endinterface

// File: rtl/tick_divider.sv
// Runtime-loadable clock-enable generator: one-cycle tick and a
// near-50% square wave per divisor period.
// Ports: clk, rst (async, active high), bus (tick_divider_if.slave):
//   en/clr/load/div_in in; tick/sq/div_q out (all registered).
module tick_divider #(
    parameter int          DIV_W       = 24,
    parameter int unsigned DEFAULT_DIV = 2_500_000
) (
    input  logic          clk,
    input  logic          rst,
    tick_divider_if.slave bus
);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;
    logic             sq_q;
    logic             sq_d;
    logic             last;

    // div_q is never below 2, so div_q-1 cannot underflow.
    assign last = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (bus.load) begin
            div_d = (bus.div_in < MIN_DIV) ? MIN_DIV : bus.div_in;
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (bus.clr) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else begin
            if (bus.en) begin
                cnt_d  = last ? '0 : cnt_q + DIV_W'(1);
                tick_d = last;
            end
            // Upper half of the count drives SQ high; when paused
            // cnt_d equals cnt_q, so SQ holds its value.
            sq_d = (cnt_d >= (div_q >> 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DEF_DIV;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign bus.tick  = tick_q;
    assign bus.sq    = sq_q;
    assign bus.div_q = div_q;
endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: hand-derived vector table, random
// stimulus against a reference model, async reset corners.
module tb_tick_divider;
    localparam int W = 8;

    typedef struct {
        logic         en;
        logic         clr;
        logic         load;
        logic [W-1:0] div_in;
        logic         tick;
        logic         sq;
        logic [W-1:0] divq;
    } vec_t;

    typedef struct {
        logic         tick;
        logic         sq;
        logic [W-1:0] divq;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[$];
    exp_t sb[$];

    int m_cnt;
    int m_div;
    int m_tick;
    int m_sq;

    tick_divider_if #(.DIV_W(W)) bus ();

    tick_divider #(
        .DIV_W(W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic l,
                       input int d, input logic t, input logic s,
                       input int q);
        vec_t v;
        v.en = e; v.clr = c; v.load = l; v.div_in = W'(d);
        v.tick = t; v.sq = s; v.divq = W'(q);
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expectation, then
    // compare the registered outputs just after the edge.
    task automatic step(input logic e, input logic c, input logic l,
                        input logic [W-1:0] d, input exp_t x,
                        input string nm);
        exp_t g;
        @(negedge clk);
        bus.en = e; bus.clr = c; bus.load = l; bus.div_in = d;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            g = sb.pop_front();
            chk({nm, "_tick"}, int'(bus.tick), int'(g.tick));
            chk({nm, "_sq"}, int'(bus.sq), int'(g.sq));
            chk({nm, "_divq"}, int'(bus.div_q), int'(g.divq));
        end
    endtask

    task automatic model(input logic e, input logic c, input logic l,
                         input int d);
        if (l) begin
            m_div = (d < 2) ? 2 : d;
            m_cnt = 0; m_tick = 0; m_sq = 0;
        end else if (c) begin
            m_cnt = 0; m_tick = 0; m_sq = 0;
        end else if (e) begin
            m_tick = (m_cnt + 1 == m_div) ? 1 : 0;
            m_cnt = (m_cnt + 1) % m_div;
            m_sq = (2 * m_cnt >= m_div - (m_div % 2)) ? 1 : 0;
        end else begin
            m_tick = 0;
        end
    endtask

    initial begin
        exp_t x;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0;
        bus.div_in = '0;
        m_cnt = 0; m_div = 4; m_tick = 0; m_sq = 0;

        // Default divisor 4: tick on 4,8,12; sq 0,1,1,0
        for (int k = 0; k < 3; k++) begin
            add(1,0,0,0, 0,0,4); add(1,0,0,0, 0,1,4);
            add(1,0,0,0, 0,1,4); add(1,0,0,0, 1,0,4);
        end
        // Clamp 0 and 1 to 2
        add(0,0,1,0, 0,0,2);
        for (int k = 0; k < 2; k++) begin
            add(1,0,0,0, 0,1,2); add(1,0,0,0, 1,0,2);
        end
        add(0,0,1,1, 0,0,2);
        for (int k = 0; k < 2; k++) begin
            add(1,0,0,0, 0,1,2); add(1,0,0,0, 1,0,2);
        end
        // Odd divisor 5 (load beats en): sq low 2, high 3
        add(1,0,1,5, 0,0,5);
        add(1,0,0,0, 0,0,5); add(1,0,0,0, 0,1,5);
        add(1,0,0,0, 0,1,5); add(1,0,0,0, 0,1,5);
        add(1,0,0,0, 1,0,5);
        add(1,0,0,0, 0,0,5); add(1,0,0,0, 0,1,5);
        // clr+load at cnt=2 of 4: tick 3 cycles later
        add(0,0,1,4, 0,0,4);
        add(1,0,0,0, 0,0,4); add(1,0,0,0, 0,1,4);
        add(1,1,1,3, 0,0,3);
        add(1,0,0,0, 0,1,3); add(1,0,0,0, 0,1,3);
        add(1,0,0,0, 1,0,3);
        // clr while paused, then 3 edges to tick
        add(1,0,0,0, 0,1,3);
        add(0,1,0,0, 0,0,3);
        add(0,0,0,0, 0,0,3); add(0,0,0,0, 0,0,3);
        add(1,0,0,0, 0,1,3); add(1,0,0,0, 0,1,3);
        add(1,0,0,0, 1,0,3);
        // pause at terminal count: tick deferred to resume
        add(1,0,0,0, 0,1,3); add(1,0,0,0, 0,1,3);
        add(0,0,0,0, 0,1,3); add(0,0,0,0, 0,1,3);
        add(0,0,0,0, 0,1,3);
        add(1,0,0,0, 1,0,3);
        // div 6, 5-cycle pause at cnt=3: 11-cycle period once
        add(0,0,1,6, 0,0,6);
        add(1,0,0,0, 0,0,6); add(1,0,0,0, 0,0,6);
        add(1,0,0,0, 0,1,6);
        for (int k = 0; k < 5; k++) add(0,0,0,0, 0,1,6);
        add(1,0,0,0, 0,1,6); add(1,0,0,0, 0,1,6);
        add(1,0,0,0, 1,0,6);
        add(1,0,0,0, 0,0,6); add(1,0,0,0, 0,0,6);
        add(1,0,0,0, 0,1,6); add(1,0,0,0, 0,1,6);
        add(1,0,0,0, 0,1,6); add(1,0,0,0, 1,0,6);
        // Largest divisor
        add(0,0,1,255, 0,0,255);
        add(1,0,0,0, 0,0,255);

        // Reset state before any clock edge
        #1;
        chk("rst0_tick", int'(bus.tick), 0);
        chk("rst0_sq", int'(bus.sq), 0);
        chk("rst0_divq", int'(bus.div_q), 4);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            x.tick = tbl[i].tick;
            x.sq = tbl[i].sq;
            x.divq = tbl[i].divq;
            step(tbl[i].en, tbl[i].clr, tbl[i].load,
                 tbl[i].div_in, x, $sformatf("vec%0d", i));
        end

        // Random stimulus against the model
        for (int i = 0; i < 300; i++) begin
            logic e, c, l;
            int d;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            l = (i == 0) || ($urandom_range(0, 24) == 0);
            d = int'($urandom_range(0, 9));
            model(e, c, l, d);
            x.tick = m_tick[0];
            x.sq = m_sq[0];
            x.divq = W'(m_div);
            step(e, c, l, W'(d), x, "rnd");
        end

        // Async reset mid-count, while sq is high
        x.tick = 0; x.sq = 0; x.divq = 6;
        step(0, 0, 1, 6, x, "pre_ld");
        step(1, 0, 0, 0, x, "pre1");
        step(1, 0, 0, 0, x, "pre2");
        x.sq = 1;
        step(1, 0, 0, 0, x, "pre3");
        step(1, 0, 0, 0, x, "pre4");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tick", int'(bus.tick), 0);
        chk("arst_sq", int'(bus.sq), 0);
        chk("arst_divq", int'(bus.div_q), 4);
        @(posedge clk);
        #1;
        chk("hold_sq", int'(bus.sq), 0);
        chk("hold_divq", int'(bus.div_q), 4);
        bus.en = 1'b0;
        rst = 1'b0;
        x.divq = 4;
        x.tick = 0; x.sq = 0; step(1, 0, 0, 0, x, "post1");
        x.sq = 1;             step(1, 0, 0, 0, x, "post2");
                              step(1, 0, 0, 0, x, "post3");
        x.tick = 1; x.sq = 0; step(1, 0, 0, 0, x, "post4");

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
